// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's two write ports (A, B) among NUM_REQ writeback
// requesters. Arbitration is round-robin and grants up to two requests per
// cycle. Two requests for the same address are never granted together.
// The block also owns the bank select and sequences bank switches, so a write
// that is already in flight always lands in the bank it was granted under.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int BANK_W  = 6
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        reqValid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr_i,
    input  logic [NUM_REQ*DATA_W-1:0] reqData_i,
    output logic [NUM_REQ-1:0]        reqReady_o,
    input  logic                      bankReq_i,
    input  logic [BANK_W-1:0]         bankNext_i,
    output logic                      bankAck_o,
    output logic [BANK_W-1:0]         bankSelect_o,
    output logic                      portAWriteEnable_o,
    output logic [ADDR_W-1:0]         portAWriteAddress_o,
    output logic [DATA_W-1:0]         portAWriteData_o,
    output logic                      portBWriteEnable_o,
    output logic [ADDR_W-1:0]         portBWriteAddress_o,
    output logic [DATA_W-1:0]         portBWriteData_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [PTR_W-1:0]    rrPtr;
    logic [PTR_W-1:0]    rrPtrNext;
    logic [PTR_W-1:0]    lastIdx;
    logic [BANK_W-1:0]   bankLatched;

    logic                aFound;
    logic                bFound;
    logic [PTR_W-1:0]    aIdx;
    logic [PTR_W-1:0]    bIdx;
    logic [PTR_W-1:0]    scanIdx;
    logic [PTR_W:0]      scanSum;
    logic [ADDR_W-1:0]   aAddr;
    logic [ADDR_W-1:0]   bAddr;
    logic [DATA_W-1:0]   aData;
    logic [DATA_W-1:0]   bData;
    logic [NUM_REQ-1:0]  ready;

    // Round-robin scan from rrPtr: the first valid request takes port A, and the
    // next valid request with a different address takes port B. Reset is
    // included here so the readies drop as soon as reset rises, without
    // waiting for a clock edge.
    always_comb begin
        aFound  = 1'b0;
        bFound  = 1'b0;
        aIdx    = '0;
        bIdx    = '0;
        aAddr   = '0;
        bAddr   = '0;
        aData   = '0;
        bData   = '0;
        scanSum = '0;
        scanIdx = '0;
        ready   = '0;
        if (state == IDLE && !bankReq_i && !reset_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scanSum = {1'b0, rrPtr} + (PTR_W+1)'(k);
                if (scanSum >= (PTR_W+1)'(NUM_REQ)) begin
                    scanSum = scanSum - (PTR_W+1)'(NUM_REQ);
                end
                scanIdx = scanSum[PTR_W-1:0];
                if (reqValid_i[scanIdx]) begin
                    if (!aFound) begin
                        aFound = 1'b1;
                        aIdx   = scanIdx;
                        aAddr  = reqAddr_i[scanIdx*ADDR_W +: ADDR_W];
                        aData  = reqData_i[scanIdx*DATA_W +: DATA_W];
                    end else if (!bFound && (reqAddr_i[scanIdx*ADDR_W +: ADDR_W] != aAddr)) begin
                        bFound = 1'b1;
                        bIdx   = scanIdx;
                        bAddr  = reqAddr_i[scanIdx*ADDR_W +: ADDR_W];
                        bData  = reqData_i[scanIdx*DATA_W +: DATA_W];
                    end
                end
            end
        end
        if (aFound) ready[aIdx] = 1'b1;
        if (bFound) ready[bIdx] = 1'b1;
    end

    // The next scan starts just after the last index granted this cycle.
    // When nothing is granted, the pointer stays where it is.
    always_comb begin
        lastIdx   = bFound ? bIdx : aIdx;
        rrPtrNext = rrPtr;
        if (aFound) begin
            rrPtrNext = (lastIdx == PTR_W'(NUM_REQ - 1)) ? '0 : lastIdx + 1'b1;
        end
    end

    // Bank-switch sequencing: IDLE waits for a request, DRAIN lets the last
    // granted writes commit under the old bank, and SWITCH presents the new bank.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bankReq_i) stateNext = DRAIN;
            DRAIN:   stateNext = SWITCH;
            SWITCH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Holds the FSM state, the target bank captured when a switch starts, and
    // the bank select, which is updated only at the end of DRAIN.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            bankLatched  <= '0;
            bankSelect_o <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && bankReq_i) begin
                bankLatched <= bankNext_i;
            end
            if (state == DRAIN) begin
                bankSelect_o <= bankLatched;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rrPtr <= '0;
        end else begin
            rrPtr <= rrPtrNext;
        end
    end

    // Write-port registers: a grant made in one cycle drives the port for
    // exactly the following cycle. Address and data are zero when a port is idle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            portAWriteEnable_o  <= 1'b0;
            portAWriteAddress_o <= '0;
            portAWriteData_o    <= '0;
            portBWriteEnable_o  <= 1'b0;
            portBWriteAddress_o <= '0;
            portBWriteData_o    <= '0;
        end else begin
            portAWriteEnable_o  <= aFound;
            portAWriteAddress_o <= aAddr;
            portAWriteData_o    <= aData;
            portBWriteEnable_o  <= bFound;
            portBWriteAddress_o <= bAddr;
            portBWriteData_o    <= bData;
        end
    end

    assign reqReady_o = ready;
    assign bankAck_o  = (state == SWITCH);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed stimulus for the write arbiter. Each stimulus step pushes the
// port writes it expects into per-port queues, and a monitor process pops
// and compares them whenever a port write strobe appears.
module tb_regfile_write_arbiter;

    logic        clock_i;
    logic        reset_i;
    logic [3:0]  reqValid_i;
    logic [19:0] reqAddr_i;
    logic [63:0] reqData_i;
    logic [3:0]  reqReady_o;
    logic        bankReq_i;
    logic [5:0]  bankNext_i;
    logic        bankAck_o;
    logic [5:0]  bankSelect_o;
    logic        portAWriteEnable_o;
    logic [4:0]  portAWriteAddress_o;
    logic [15:0] portAWriteData_o;
    logic        portBWriteEnable_o;
    logic [4:0]  portBWriteAddress_o;
    logic [15:0] portBWriteData_o;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t expA[$];
    wr_t expB[$];
    int  cycleCount;
    int  total;
    int  bad;

    regfile_write_arbiter #(
        .NUM_REQ(4), .ADDR_W(5), .DATA_W(16), .BANK_W(6)
    ) dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .reqValid_i         (reqValid_i),
        .reqAddr_i          (reqAddr_i),
        .reqData_i          (reqData_i),
        .reqReady_o         (reqReady_o),
        .bankReq_i          (bankReq_i),
        .bankNext_i         (bankNext_i),
        .bankAck_o          (bankAck_o),
        .bankSelect_o       (bankSelect_o),
        .portAWriteEnable_o (portAWriteEnable_o),
        .portAWriteAddress_o(portAWriteAddress_o),
        .portAWriteData_o   (portAWriteData_o),
        .portBWriteEnable_o (portBWriteEnable_o),
        .portBWriteAddress_o(portBWriteAddress_o),
        .portBWriteData_o   (portBWriteData_o)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Cycle stamp used to check write latency.
    always @(posedge clock_i) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of requests at the falling edge, checks the readies and
    // queues the port writes expected on the following cycle.
    task automatic applyStimulus(
        input string       name,
        input logic [3:0]  valid,
        input logic [19:0] addrs,
        input logic [63:0] datas,
        input logic        bReq,
        input logic [5:0]  bNext,
        input logic [3:0]  expReady,
        input logic        aEn,
        input logic [4:0]  aAddr,
        input logic [15:0] aData,
        input logic        bEn,
        input logic [4:0]  bAddr,
        input logic [15:0] bData
    );
        wr_t w;
        @(negedge clock_i);
        reqValid_i = valid;
        reqAddr_i  = addrs;
        reqData_i  = datas;
        bankReq_i  = bReq;
        bankNext_i = bNext;
        #1;
        checkOutput({name, " ready"}, 32'(reqReady_o), 32'(expReady));
        if (aEn) begin
            w.cyc = cycleCount + 1; w.addr = aAddr; w.data = aData;
            expA.push_back(w);
        end
        if (bEn) begin
            w.cyc = cycleCount + 1; w.addr = bAddr; w.data = bData;
            expB.push_back(w);
        end
    endtask

    // Monitor: every asserted write strobe must match the oldest expected write
    // for that port, including the cycle in which it was expected.
    initial begin
        wr_t w;
        forever begin
            @(posedge clock_i);
            #1;
            if (!reset_i) begin
                if (portAWriteEnable_o) begin
                    total++;
                    if (expA.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL portA unexpected: got addr=%0h data=%0h expected no write",
                                 portAWriteAddress_o, portAWriteData_o);
                    end else begin
                        w = expA.pop_front();
                        if (portAWriteAddress_o !== w.addr || portAWriteData_o !== w.data || cycleCount != w.cyc) begin
                            bad++;
                            $display("[TB] FAIL portA write: got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                                     portAWriteAddress_o, portAWriteData_o, cycleCount, w.addr, w.data, w.cyc);
                        end
                    end
                end
                if (portBWriteEnable_o) begin
                    total++;
                    if (expB.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL portB unexpected: got addr=%0h data=%0h expected no write",
                                 portBWriteAddress_o, portBWriteData_o);
                    end else begin
                        w = expB.pop_front();
                        if (portBWriteAddress_o !== w.addr || portBWriteData_o !== w.data || cycleCount != w.cyc) begin
                            bad++;
                            $display("[TB] FAIL portB write: got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                                     portBWriteAddress_o, portBWriteData_o, cycleCount, w.addr, w.data, w.cyc);
                        end
                    end
                end
            end
        end
    end

    // Main directed sequence.
    initial begin
        total      = 0;
        bad        = 0;
        cycleCount = 0;
        reset_i    = 1'b1;
        reqValid_i = '0;
        reqAddr_i  = '0;
        reqData_i  = '0;
        bankReq_i  = 1'b0;
        bankNext_i = '0;
        repeat (2) @(posedge clock_i);
        #1;
        checkOutput("reset bankSelect", 32'(bankSelect_o), 32'h0);
        checkOutput("reset ack", 32'(bankAck_o), 32'h0);
        checkOutput("reset enA", 32'(portAWriteEnable_o), 32'h0);
        checkOutput("reset enB", 32'(portBWriteEnable_o), 32'h0);
        checkOutput("reset ready", 32'(reqReady_o), 32'h0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Two distinct requests from pointer 0; the pointer then moves to 3.
        applyStimulus("pair02", 4'b0101, {5'd0, 5'd7, 5'd0, 5'd3}, {16'h0, 16'hBEEF, 16'h0, 16'h1234},
                      1'b0, 6'd0, 4'b0101, 1'b1, 5'd3, 16'h1234, 1'b1, 5'd7, 16'hBEEF);
        // With the pointer at 3, req3 wins; req0 has the same address and waits.
        applyStimulus("ptr3 conflict", 4'b1001, {5'd9, 5'd0, 5'd0, 5'd9}, {16'h3333, 16'h0, 16'h0, 16'h0A0A},
                      1'b0, 6'd0, 4'b1000, 1'b1, 5'd9, 16'h3333, 1'b0, 5'd0, 16'h0);
        // All four requests held: grant pairs {0,1}, {2,3}, {0,1}.
        applyStimulus("all4 a", 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                      1'b0, 6'd0, 4'b0011, 1'b1, 5'd1, 16'h1111, 1'b1, 5'd2, 16'h2222);
        applyStimulus("all4 b", 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                      1'b0, 6'd0, 4'b1100, 1'b1, 5'd3, 16'h3333, 1'b1, 5'd4, 16'h4444);
        applyStimulus("all4 c", 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                      1'b0, 6'd0, 4'b0011, 1'b1, 5'd1, 16'h1111, 1'b1, 5'd2, 16'h2222);
        // Single grant to req3, which brings the pointer back to 0.
        applyStimulus("single3", 4'b1000, {5'd6, 5'd0, 5'd0, 5'd0}, {16'h6666, 16'h0, 16'h0, 16'h0},
                      1'b0, 6'd0, 4'b1000, 1'b1, 5'd6, 16'h6666, 1'b0, 5'd0, 16'h0);
        // Same-address requests are serialised: req1 first, then req3.
        applyStimulus("sameaddr 1", 4'b1010, {5'd5, 5'd0, 5'd5, 5'd0}, {16'h5353, 16'h0, 16'h5151, 16'h0},
                      1'b0, 6'd0, 4'b0010, 1'b1, 5'd5, 16'h5151, 1'b0, 5'd0, 16'h0);
        applyStimulus("sameaddr 2", 4'b1000, {5'd5, 5'd0, 5'd5, 5'd0}, {16'h5353, 16'h0, 16'h5151, 16'h0},
                      1'b0, 6'd0, 4'b1000, 1'b1, 5'd5, 16'h5353, 1'b0, 5'd0, 16'h0);

        // Bank switch: grant req0 in T, then request a switch to bank 1 in T+1.
        applyStimulus("bank T", 4'b0001, {5'd0, 5'd0, 5'd0, 5'd4}, {16'h0, 16'h0, 16'h0, 16'h4444},
                      1'b0, 6'd0, 4'b0001, 1'b1, 5'd4, 16'h4444, 1'b0, 5'd0, 16'h0);
        applyStimulus("bank T+1", 4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, {16'h0, 16'h0, 16'h8888, 16'h0},
                      1'b1, 6'd1, 4'b0000, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
        checkOutput("bank T+1 select", 32'(bankSelect_o), 32'h0);
        checkOutput("bank T+1 ack", 32'(bankAck_o), 32'h0);
        applyStimulus("bank T+2", 4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, {16'h0, 16'h0, 16'h8888, 16'h0},
                      1'b1, 6'd1, 4'b0000, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
        checkOutput("bank T+2 select", 32'(bankSelect_o), 32'h0);
        checkOutput("bank T+2 ack", 32'(bankAck_o), 32'h0);
        applyStimulus("bank T+3", 4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, {16'h0, 16'h0, 16'h8888, 16'h0},
                      1'b1, 6'd1, 4'b0000, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
        checkOutput("bank T+3 select", 32'(bankSelect_o), 32'h1);
        checkOutput("bank T+3 ack", 32'(bankAck_o), 32'h1);
        applyStimulus("bank T+4", 4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, {16'h0, 16'h0, 16'h8888, 16'h0},
                      1'b0, 6'd1, 4'b0010, 1'b1, 5'd8, 16'h8888, 1'b0, 5'd0, 16'h0);
        checkOutput("bank T+4 select", 32'(bankSelect_o), 32'h1);
        checkOutput("bank T+4 ack", 32'(bankAck_o), 32'h0);

        // Reset in the middle of traffic clears the outputs before the next edge.
        applyStimulus("pre-reset", 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                      1'b0, 6'd0, 4'b1100, 1'b1, 5'd3, 16'h3333, 1'b1, 5'd4, 16'h4444);
        @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("midreset ready", 32'(reqReady_o), 32'h0);
        checkOutput("midreset enA", 32'(portAWriteEnable_o), 32'h0);
        checkOutput("midreset enB", 32'(portBWriteEnable_o), 32'h0);
        checkOutput("midreset select", 32'(bankSelect_o), 32'h0);
        @(negedge clock_i);
        reset_i    = 1'b0;
        reqValid_i = '0;

        // Reset while in DRAIN aborts the switch with no acknowledge.
        applyStimulus("drain start", 4'b0000, 20'h0, 64'h0, 1'b1, 6'd5, 4'b0000,
                      1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
        @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("drain reset select", 32'(bankSelect_o), 32'h0);
        checkOutput("drain reset ack", 32'(bankAck_o), 32'h0);
        @(negedge clock_i);
        reset_i   = 1'b0;
        bankReq_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_i);
            #1;
            checkOutput("post-abort ack", 32'(bankAck_o), 32'h0);
            checkOutput("post-abort select", 32'(bankSelect_o), 32'h0);
        end
        // The FSM is back in IDLE with the pointer cleared, so req2 is granted.
        applyStimulus("post-abort grant", 4'b0100, {5'd0, 5'd2, 5'd0, 5'd0}, {16'h0, 16'h2222, 16'h0, 16'h0},
                      1'b0, 6'd0, 4'b0100, 1'b1, 5'd2, 16'h2222, 1'b0, 5'd0, 16'h0);
        @(negedge clock_i);
        reqValid_i = '0;
        repeat (3) @(negedge clock_i);

        checkOutput("portA queue drained", 32'(expA.size()), 32'h0);
        checkOutput("portB queue drained", 32'(expB.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
